// File: rtl/pbkdf2_pkg.sv
// Shared field widths and arbiter FSM encoding for the pbkdf2 arbiter slice.
package pbkdf2_pkg;

  localparam int unsigned SaltLenW = 6;
  localparam int unsigned ItersW   = 32;
  localparam int unsigned PassW    = 512;
  localparam int unsigned SaltW    = 512;
  localparam int unsigned HashW    = 256;

  // Arbiter FSM states, kept as plain constants for legacy tool compatibility
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t StIdle  = 2'd0;
  localparam arb_state_t StIssue = 2'd1;
  localparam arb_state_t StBusy  = 2'd2;
  localparam arb_state_t StResp  = 2'd3;

endpackage

// File: rtl/pbkdf2_rr_arb.sv
// Round-robin selector: first asserted request at or after ptr_i, wrapping.
module pbkdf2_rr_arb
  import pbkdf2_pkg::*;
#(
  parameter int unsigned NUM_REQ_P = 4,
  parameter int unsigned ID_W_P    = 2
) (
  input  logic [NUM_REQ_P-1:0] req_i,
  input  logic [ID_W_P-1:0]    ptr_i,
  output logic [NUM_REQ_P-1:0] gnt_o,
  output logic [ID_W_P-1:0]    gnt_id_o,
  output logic                 any_o
);

  logic [ID_W_P-1:0] idx;

  // Scan requesters starting at the pointer; the first hit wins
  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    any_o    = 1'b0;
    idx      = '0;
    for (int unsigned off = 0; off < NUM_REQ_P; off++) begin
      idx = ID_W_P'((32'(ptr_i) + off) % NUM_REQ_P);
      if (!any_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_id_o   = idx;
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pbkdf2_arb.sv
// Shares one pbkdf2 core between NUM_REQ_P requesters, one job in flight.
// Optional perf counters are built when PBKDF2_ARB_PERF_EN is defined.
module pbkdf2_arb
  import pbkdf2_pkg::*;
#(
  parameter int unsigned NUM_REQ_P = 4,
  parameter int unsigned ID_W_P    = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ_P-1:0]          req_valid_i,
  output logic [NUM_REQ_P-1:0]          req_ready_o,
  input  logic [NUM_REQ_P*SaltLenW-1:0] req_salt_len_i,
  input  logic [NUM_REQ_P*ItersW-1:0]   req_iters_i,
  input  logic [NUM_REQ_P*PassW-1:0]    req_pass_i,
  input  logic [NUM_REQ_P*SaltW-1:0]    req_salt_i,
  output logic [SaltLenW-1:0]           core_salt_len_o,
  output logic [ItersW-1:0]             core_iters_o,
  output logic [PassW-1:0]              core_pass_o,
  output logic [SaltW-1:0]              core_salt_o,
  output logic                          core_in_valid_o,
  input  logic                          core_in_ready_i,
  input  logic [HashW-1:0]              core_hash_i,
  input  logic                          core_out_valid_i,
  output logic                          core_out_ready_o,
`ifdef PBKDF2_ARB_PERF_EN
  output logic [31:0]                   perf_jobs_o,
  output logic [31:0]                   perf_busy_o,
`endif
  output logic                          resp_valid_o,
  input  logic                          resp_ready_i,
  output logic [ID_W_P-1:0]             resp_id_o,
  output logic [HashW-1:0]              resp_hash_o
);

  localparam logic [ID_W_P-1:0] LastId = ID_W_P'(NUM_REQ_P - 1);

  arb_state_t          state_q, state_d;
  logic [ID_W_P-1:0]   rr_q, rr_d;
  logic [ID_W_P-1:0]   id_q, id_d;
  logic [SaltLenW-1:0] salt_len_q, salt_len_d;
  logic [ItersW-1:0]   iters_q, iters_d;
  logic [PassW-1:0]    pass_q, pass_d;
  logic [SaltW-1:0]    salt_q, salt_d;
  logic [HashW-1:0]    hash_q, hash_d;

  logic [NUM_REQ_P-1:0] gnt;
  logic [ID_W_P-1:0]    gnt_id;
  logic                 gnt_any;

  pbkdf2_rr_arb #(
    .NUM_REQ_P (NUM_REQ_P),
    .ID_W_P    (ID_W_P)
  ) u_rr_arb (
    .req_i    (req_valid_i),
    .ptr_i    (rr_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id),
    .any_o    (gnt_any)
  );

  // Next-state: grant/latch in idle, handshake through core, hold response
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    id_d       = id_q;
    salt_len_d = salt_len_q;
    iters_d    = iters_q;
    pass_d     = pass_q;
    salt_d     = salt_q;
    hash_d     = hash_q;
    case (state_q)
      StIdle: begin
        if (gnt_any) begin
          state_d    = StIssue;
          id_d       = gnt_id;
          salt_len_d = req_salt_len_i[32'(gnt_id) * SaltLenW +: SaltLenW];
          iters_d    = req_iters_i[32'(gnt_id) * ItersW +: ItersW];
          pass_d     = req_pass_i[32'(gnt_id) * PassW +: PassW];
          salt_d     = req_salt_i[32'(gnt_id) * SaltW +: SaltW];
        end
      end
      StIssue: begin
        if (core_in_ready_i) state_d = StBusy;
      end
      StBusy: begin
        if (core_out_valid_i) begin
          state_d = StResp;
          hash_d  = core_hash_i;
        end
      end
      StResp: begin
        if (resp_ready_i) begin
          state_d = StIdle;
          rr_d    = (id_q == LastId) ? '0 : id_q + ID_W_P'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and job registers; reset drops any job in flight
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      rr_q       <= '0;
      id_q       <= '0;
      salt_len_q <= '0;
      iters_q    <= '0;
      pass_q     <= '0;
      salt_q     <= '0;
      hash_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      id_q       <= id_d;
      salt_len_q <= salt_len_d;
      iters_q    <= iters_d;
      pass_q     <= pass_d;
      salt_q     <= salt_d;
      hash_q     <= hash_d;
    end
  end

  // Handshake outputs are pure state decodes
  always_comb begin
    req_ready_o      = (state_q == StIdle) ? gnt : '0;
    core_in_valid_o  = (state_q == StIssue);
    core_out_ready_o = (state_q == StBusy);
    resp_valid_o     = (state_q == StResp);
    core_salt_len_o  = salt_len_q;
    core_iters_o     = iters_q;
    core_pass_o      = pass_q;
    core_salt_o      = salt_q;
    resp_id_o        = id_q;
    resp_hash_o      = hash_q;
  end

`ifdef PBKDF2_ARB_PERF_EN
  logic [31:0] perf_jobs_q;
  logic [31:0] perf_busy_q;

  // Saturating job and busy-cycle counters
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_jobs_q <= '0;
      perf_busy_q <= '0;
    end else begin
      if (state_q == StResp && resp_ready_i && perf_jobs_q != '1) begin
        perf_jobs_q <= perf_jobs_q + 32'd1;
      end
      if ((state_q == StIssue || state_q == StBusy) && perf_busy_q != '1) begin
        perf_busy_q <= perf_busy_q + 32'd1;
      end
    end
  end

  assign perf_jobs_o = perf_jobs_q;
  assign perf_busy_o = perf_busy_q;
`endif

endmodule

// File: tb/tb_pbkdf2_arb.sv
// Scoreboard bench for pbkdf2_arb with a behavioural core stand-in.
`timescale 1ns/1ps
module tb_pbkdf2_arb;
  import pbkdf2_pkg::*;

  localparam int N = 4;
  localparam logic [255:0] RfcHash =
    256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
  localparam logic [511:0] RfcPass = 512'h70617373776f7264; // "password"
  localparam logic [511:0] RfcSalt = 512'h73616c74;         // "salt"

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*6-1:0]   req_salt_len;
  logic [N*32-1:0]  req_iters;
  logic [N*512-1:0] req_pass, req_salt;
  logic [5:0]     core_salt_len;
  logic [31:0]    core_iters;
  logic [511:0]   core_pass, core_salt;
  logic           core_in_valid, core_in_ready, core_out_valid, core_out_ready;
  logic [255:0]   core_hash;
  logic           resp_valid, resp_ready;
  logic [1:0]     resp_id;
  logic [255:0]   resp_hash;
`ifdef PBKDF2_ARB_PERF_EN
  logic [31:0]    perf_jobs, perf_busy;
`endif

  logic [5:0]   sl_a[N];
  logic [31:0]  it_a[N];
  logic [511:0] pass_a[N];
  logic [511:0] salt_a[N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_salt_len[g*6 +: 6]  = sl_a[g];
    assign req_iters[g*32 +: 32]   = it_a[g];
    assign req_pass[g*512 +: 512]  = pass_a[g];
    assign req_salt[g*512 +: 512]  = salt_a[g];
  end

  always #5 clk = ~clk;

  pbkdf2_arb #(.NUM_REQ_P(N), .ID_W_P(2)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_salt_len_i   (req_salt_len),
    .req_iters_i      (req_iters),
    .req_pass_i       (req_pass),
    .req_salt_i       (req_salt),
    .core_salt_len_o  (core_salt_len),
    .core_iters_o     (core_iters),
    .core_pass_o      (core_pass),
    .core_salt_o      (core_salt),
    .core_in_valid_o  (core_in_valid),
    .core_in_ready_i  (core_in_ready),
    .core_hash_i      (core_hash),
    .core_out_valid_i (core_out_valid),
    .core_out_ready_o (core_out_ready),
`ifdef PBKDF2_ARB_PERF_EN
    .perf_jobs_o      (perf_jobs),
    .perf_busy_o      (perf_busy),
`endif
    .resp_valid_o     (resp_valid),
    .resp_ready_i     (resp_ready),
    .resp_id_o        (resp_id),
    .resp_hash_o      (resp_hash)
  );

  // Stand-in core: the known test vector hashes to its published value,
  // anything else hashes to a packing of the job fields it was handed.
  function automatic logic [255:0] core_fn(input logic [5:0] sl, input logic [31:0] it,
                                           input logic [511:0] p, input logic [511:0] s);
    if (sl == 6'd4 && it == 32'd1 && p == RfcPass && s == RfcSalt) return RfcHash;
    return {it, 26'd0, sl, p[95:0], s[95:0]};
  endfunction

  logic         rdy_en = 1'b1, spur = 1'b0, cm_pend = 1'b0, cm_out_valid = 1'b0;
  logic [7:0]   core_lat = 8'd3, cm_cnt = 8'd0;
  logic [255:0] cm_hash = '0;
  int           cyc = 0;

  assign core_in_ready  = rdy_en;
  assign core_out_valid = cm_out_valid | spur;
  assign core_hash      = cm_hash;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!rst_n) begin
      cm_pend      <= 1'b0;
      cm_cnt       <= 8'd0;
      cm_out_valid <= 1'b0;
    end else if (cm_out_valid) begin
      if (core_out_ready) begin
        cm_out_valid <= 1'b0;
        cm_pend      <= 1'b0;
      end
    end else if (cm_pend) begin
      if (cm_cnt == 8'd0) cm_out_valid <= 1'b1;
      else cm_cnt <= cm_cnt - 8'd1;
    end else if (core_in_valid && core_in_ready) begin
      cm_pend <= 1'b1;
      cm_cnt  <= core_lat;
      cm_hash <= core_fn(core_salt_len, core_iters, core_pass, core_salt);
    end
  end

  typedef struct {
    logic [1:0]   id;
    logic [255:0] hash;
  } exp_t;

  exp_t exp_q[$];
  int   exp_gnt_q[$];
  int   n_checks = 0, n_errors = 0;
  int   gnt_count = 0, resp_count = 0;
  int   acc_cyc = 0, resp_rise_cyc = 0;
  int   jobs_since_rst = 0, busy_since_rst = 0;
  logic rv_prev = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input int got);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %0d, nothing expected", name, got);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input int i);
    exp_t e;
    e.id   = 2'(i);
    e.hash = core_fn(sl_a[i], it_a[i], pass_a[i], salt_a[i]);
    exp_gnt_q.push_back(i);
    exp_q.push_back(e);
  endtask

  task automatic wait_gnt(input int target);
    int k = 0;
    while (gnt_count < target && k < 200) begin
      tick();
      k++;
    end
    if (gnt_count < target) note_fail("grant_timeout", gnt_count);
  endtask

  task automatic wait_resp(input int target);
    int k = 0;
    while (resp_count < target && k < 400) begin
      tick();
      k++;
    end
    if (resp_count < target) note_fail("resp_timeout", resp_count);
  endtask

  // Monitor: pops expected grants and responses as the DUT handshakes
  initial begin
    int   gid;
    int   g;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rv_prev        = 1'b0;
        jobs_since_rst = 0;
        busy_since_rst = 0;
      end else begin
        if (core_in_valid || core_out_ready) busy_since_rst++;
        if (resp_valid && !rv_prev) resp_rise_cyc = cyc;
        rv_prev = resp_valid;
        if ((req_valid & req_ready) != '0) begin
          check("ready_onehot", 256'($countones(req_ready)), 256'd1);
          gid = 0;
          for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
          acc_cyc = cyc + 1;
          if (exp_gnt_q.size() == 0) note_fail("unexpected_grant", gid);
          else begin
            g = exp_gnt_q.pop_front();
            check("grant_id", 256'(gid), 256'(g));
          end
          gnt_count++;
        end
        if (resp_valid && resp_ready) begin
          if (exp_q.size() == 0) note_fail("unexpected_resp", int'(resp_id));
          else begin
            e = exp_q.pop_front();
            check("resp_id", 256'(resp_id), 256'(e.id));
            check("resp_hash", resp_hash, e.hash);
          end
          resp_count++;
          jobs_since_rst++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_idle_zero(input string tag);
    check({tag, "_resp_valid"}, 256'(resp_valid), 256'd0);
    check({tag, "_core_in_valid"}, 256'(core_in_valid), 256'd0);
    check({tag, "_core_out_ready"}, 256'(core_out_ready), 256'd0);
    check({tag, "_req_ready"}, 256'(req_ready), 256'd0);
    check({tag, "_resp_id"}, 256'(resp_id), 256'd0);
    check({tag, "_resp_hash"}, resp_hash, 256'd0);
    check({tag, "_core_iters"}, 256'(core_iters), 256'd0);
    check({tag, "_core_salt_len"}, 256'(core_salt_len), 256'd0);
    check({tag, "_core_pass"}, core_pass[255:0] | core_pass[511:256], 256'd0);
    check({tag, "_core_salt"}, core_salt[255:0] | core_salt[511:256], 256'd0);
  endtask

  initial begin
    req_valid  = '0;
    resp_ready = 1'b1;
    sl_a[0] = 6'd4;  it_a[0] = 32'd1;    pass_a[0] = RfcPass; salt_a[0] = RfcSalt;
    sl_a[1] = 6'd16; it_a[1] = 32'd1000;
    pass_a[1] = 512'h1111_2222_3333_4444_5555_6666; salt_a[1] = 512'ha1a1_b2b2_c3c3;
    sl_a[2] = 6'd8;  it_a[2] = 32'd1;
    pass_a[2] = 512'h7777_8888_9999_aaaa_bbbb_cccc; salt_a[2] = 512'hd4d4_e5e5_f6f6;
    // Zero iterations must reach the core untouched
    sl_a[3] = 6'd63; it_a[3] = 32'd0;
    pass_a[3] = 512'hdead_beef_0123_4567_89ab_cdef; salt_a[3] = 512'h0f0f_1e1e_2d2d_3c3c;

    repeat (3) tick();
    check_idle_zero("rst");
    rst_n = 1'b1;
    tick();

    // Known-answer job from requester 0, plus accept-to-response latency
    push_job(0);
    req_valid[0] = 1'b1;
    wait_gnt(1);
    req_valid = '0;
    wait_resp(1);
    // ISSUE cycle + core handshake edge + lat countdown + out_valid edge + capture edge
    check("latency", 256'(resp_rise_cyc - acc_cyc), 256'(int'(core_lat) + 3));

    // Lone requester 3 exercises the pointer wrap back to 0
    push_job(3);
    req_valid[3] = 1'b1;
    wait_gnt(2);
    req_valid = '0;
    wait_resp(2);

    // Everyone asking continuously: strict rotation from 0
    push_job(0); push_job(1); push_job(2); push_job(3); push_job(0);
    req_valid = '1;
    wait_gnt(7);
    req_valid = '0;
    wait_resp(7);

    // Response stall: outputs hold, nobody is accepted meanwhile
    push_job(2);
    resp_ready   = 1'b0;
    req_valid[2] = 1'b1;
    wait_gnt(8);
    req_valid = '0;
    for (int k = 0; k < 50 && !resp_valid; k++) tick();
    req_valid = 4'b1011;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("stall_resp_valid", 256'(resp_valid), 256'd1);
      check("stall_resp_id", 256'(resp_id), 256'd2);
      check("stall_resp_hash", resp_hash, core_fn(sl_a[2], it_a[2], pass_a[2], salt_a[2]));
      check("stall_req_ready", 256'(req_ready), 256'd0);
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    wait_resp(8);

    // Core input stall with a stray core_out_valid that must be ignored
    rdy_en = 1'b0;
    push_job(1);
    req_valid[1] = 1'b1;
    wait_gnt(9);
    req_valid = '0;
    spur = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("hold_in_valid", 256'(core_in_valid), 256'd1);
      check("hold_iters", 256'(core_iters), 256'(it_a[1]));
      check("hold_salt_len", 256'(core_salt_len), 256'(sl_a[1]));
      check("hold_pass", 256'(core_pass != pass_a[1]), 256'd0);
      check("hold_salt", 256'(core_salt != salt_a[1]), 256'd0);
      check("hold_out_ready", 256'(core_out_ready), 256'd0);
      check("hold_resp_valid", 256'(resp_valid), 256'd0);
      tick();
    end
    spur   = 1'b0;
    rdy_en = 1'b1;
    wait_resp(9);

    // Stray core_out_valid while idle
    spur = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("idle_spur_resp_valid", 256'(resp_valid), 256'd0);
      check("idle_spur_out_ready", 256'(core_out_ready), 256'd0);
      check("idle_spur_in_valid", 256'(core_in_valid), 256'd0);
    end
    spur = 1'b0;

    // Reset during BUSY drops the job; afterwards pointer must be back at 0
    core_lat = 8'd8;
    exp_gnt_q.push_back(3);
    req_valid[3] = 1'b1;
    wait_gnt(10);
    req_valid = '0;
    for (int k = 0; k < 20 && !core_out_ready; k++) tick();
    check("reached_busy", 256'(core_out_ready), 256'd1);
    rst_n = 1'b0;
    tick();
    check_idle_zero("midrst");
    rst_n    = 1'b1;
    core_lat = 8'd2;
    // With pointer 0, requester 1 beats requester 2
    push_job(1);
    push_job(2);
    req_valid = 4'b0110;
    wait_gnt(11);
    req_valid[1] = 1'b0;
    wait_gnt(12);
    req_valid = '0;
    wait_resp(11);

    check("exp_resp_drained", 256'(exp_q.size()), 256'd0);
    check("exp_gnt_drained", 256'(exp_gnt_q.size()), 256'd0);
`ifdef PBKDF2_ARB_PERF_EN
    check("perf_jobs", 256'(perf_jobs), 256'(jobs_since_rst));
    check("perf_jobs_two", 256'(perf_jobs), 256'd2);
    check("perf_busy", 256'(perf_busy), 256'(busy_since_rst));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
